// File: rtl/instr_fetch_if.sv
// Instruction bus between the fetch stage, instruction memory and the decoder.
// The master side (fetch) drives the address and the issued instruction.
interface instr_fetch_if #(
  parameter int PC_W = 10
) ();

  logic [PC_W-1:0] imem_addr;
  logic [8:0]      imem_rdata;
  logic [8:0]      instr;
  logic            instr_valid;
  logic            branch_taken;

  modport master (
    output imem_addr,
    output instr,
    output instr_valid,
    input  imem_rdata,
    input  branch_taken
  );

  modport slave (
    input  imem_addr,
    input  instr,
    input  instr_valid,
    output imem_rdata,
    output branch_taken
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the program counter, issues one instruction per cycle
// and resolves taken branches through a 16-entry signed-offset jump table.
module instr_fetch #(
  parameter int         PC_W       = 10,
  parameter logic [8:0] HALT_INSTR = 9'h1FF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  output logic            done,
  instr_fetch_if.master   bus,
  input  logic            lut_we,
  input  logic [3:0]      lut_idx,
  input  logic [PC_W-1:0] lut_data,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     instr_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [PC_W-1:0] pc_next;
  logic [15:0]     count_next;
  logic [PC_W-1:0] jump_lut [16];
  logic            is_halt;
  logic            issue;

  // Issue is purely combinational from pc so the decoder sees zero latency.
  assign is_halt         = (bus.imem_rdata == HALT_INSTR);
  assign issue           = (state == RUN) && !is_halt;
  assign bus.imem_addr   = pc;
  assign bus.instr       = issue ? bus.imem_rdata : 9'd0;
  assign bus.instr_valid = issue;
  assign done            = (state == HALTED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr_count <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr_count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    count_next = instr_count;
    unique case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_next = RUN;
          pc_next    = start_pc;
          count_next = '0;
        end
      end
      RUN: begin
        if (is_halt) begin
          state_next = HALTED;
        end else begin
          // Offsets are PC_W wide, so modulo-2^PC_W addition is the sign extension.
          if (bus.branch_taken) begin
            pc_next = pc + jump_lut[bus.imem_rdata[3:0]];
          end else begin
            pc_next = pc + PC_W'(1);
          end
          if (instr_count != 16'hFFFF) begin
            count_next = instr_count + 16'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A write lands at the clock edge, so a same-cycle lookup still reads the old entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        jump_lut[i] <= '0;
      end
    end else if (lut_we) begin
      jump_lut[lut_idx] <= lut_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a reference model walks each program and queues the expected
// issue stream; a negedge monitor pops and compares whatever the DUT issues.
module tb_instr_fetch;

  localparam logic [8:0] HALT = 9'h1FF;

  typedef struct packed {
    logic [9:0] pc;
    logic [8:0] instr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  start_pc;
  logic        done;
  logic        lut_we;
  logic [3:0]  lut_idx;
  logic [9:0]  lut_data;
  logic [9:0]  pc;
  logic [15:0] instr_count;

  logic [8:0]  mem      [1024];
  bit          taken_at [1024];
  logic [9:0]  lut_model [16];
  exp_t        sb [$];
  bit          mon_en;
  int          checks;
  int          failures;

  instr_fetch_if #(.PC_W(10)) bus ();

  instr_fetch #(.PC_W(10), .HALT_INSTR(HALT)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_pc    (start_pc),
    .done        (done),
    .bus         (bus),
    .lut_we      (lut_we),
    .lut_idx     (lut_idx),
    .lut_data    (lut_data),
    .pc          (pc),
    .instr_count (instr_count)
  );

  assign bus.imem_rdata   = mem[bus.imem_addr];
  assign bus.branch_taken = taken_at[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && mon_en) begin
      if (bus.instr_valid) begin
        if (sb.size() == 0) begin
          check_output("unexpected_issue_pc", {22'd0, pc}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_output("issue_pc", {22'd0, pc}, {22'd0, e.pc});
          check_output("issue_instr", {23'd0, bus.instr}, {23'd0, e.instr});
        end
      end else begin
        check_output("invalid_instr_zero", {23'd0, bus.instr}, 32'd0);
      end
    end
  end

  task automatic clear_program();
    for (int i = 0; i < 1024; i++) begin
      mem[i]      = HALT;
      taken_at[i] = 1'b0;
    end
  endtask

  // Reference model: walk the program by the architectural rules until HALT.
  task automatic build_expected(input logic [9:0] spc, input bit push,
                                output logic [9:0] halt_pc, output int n, output bit ok);
    logic [9:0] p;
    logic [8:0] w;
    p  = spc;
    n  = 0;
    ok = 1'b0;
    while (n < 600) begin
      w = mem[p];
      if (w == HALT) begin
        ok = 1'b1;
        break;
      end
      if (push) sb.push_back('{pc: p, instr: w});
      if (taken_at[p]) p = p + lut_model[w[3:0]];
      else             p = p + 10'd1;
      n++;
    end
    halt_pc = p;
  endtask

  task automatic write_lut(input logic [3:0] idx, input logic [9:0] data);
    @(negedge clk);
    lut_we   = 1'b1;
    lut_idx  = idx;
    lut_data = data;
    @(posedge clk);
    #1;
    lut_we         = 1'b0;
    lut_model[idx] = data;
  endtask

  task automatic apply_stimulus(input logic [9:0] spc);
    @(negedge clk);
    start    = 1'b1;
    start_pc = spc;
    @(posedge clk);
    #1;
    start    = 1'b0;
    start_pc = 10'($urandom);
  endtask

  // action 1 = stray start pulse, action 2 = LUT write, both in RUN cycle action_cycle.
  task automatic run_program(input logic [9:0] spc, input int action, input int action_cycle,
                             input logic [3:0] a_idx, input logic [9:0] a_data);
    logic [9:0] hp;
    int         n;
    int         cyc;
    bit         ok;
    bit         finished;
    build_expected(spc, 1'b1, hp, n, ok);
    apply_stimulus(spc);
    cyc      = 0;
    finished = 1'b0;
    while (cyc < n + 50) begin
      if (cyc == action_cycle && action == 1) begin
        start    = 1'b1;
        start_pc = 10'($urandom);
      end else if (cyc == action_cycle && action == 2) begin
        lut_we   = 1'b1;
        lut_idx  = a_idx;
        lut_data = a_data;
      end
      @(posedge clk);
      #1;
      start  = 1'b0;
      lut_we = 1'b0;
      if (action == 2 && cyc == action_cycle) lut_model[a_idx] = a_data;
      cyc++;
      if (done) begin
        finished = 1'b1;
        break;
      end
    end
    check_output("halt_reached", {31'd0, finished}, 32'd1);
    check_output("halt_latency", cyc, n + 1);
    @(negedge clk);
    check_output("halt_pc", {22'd0, pc}, {22'd0, hp});
    check_output("halt_count", {16'd0, instr_count}, n);
    check_output("halt_done", {31'd0, done}, 32'd1);
    check_output("halt_valid", {31'd0, bus.instr_valid}, 32'd0);
    check_output("queue_drained", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    logic [9:0] hp;
    logic [9:0] spc;
    int         n;
    bit         ok;
    bit         hit;

    checks   = 0;
    failures = 0;
    mon_en   = 1'b1;
    reset    = 1'b1;
    start    = 1'b0;
    start_pc = '0;
    lut_we   = 1'b0;
    lut_idx  = '0;
    lut_data = '0;
    for (int i = 0; i < 16; i++) lut_model[i] = '0;
    clear_program();
    mem[0] = 9'h011;

    #12;
    check_output("reset_pc", {22'd0, pc}, 32'd0);
    check_output("reset_done", {31'd0, done}, 32'd0);
    check_output("reset_valid", {31'd0, bus.instr_valid}, 32'd0);
    check_output("reset_count", {16'd0, instr_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_output("idle_valid", {31'd0, bus.instr_valid}, 32'd0);
    check_output("idle_pc", {22'd0, pc}, 32'd0);

    $display("[TB] basic program");
    clear_program();
    write_lut(4'd2, 10'd5);
    mem[10] = 9'h040;
    mem[11] = 9'h041;
    run_program(10'd10, 0, -1, 4'd0, 10'd0);

    $display("[TB] forward branch");
    clear_program();
    write_lut(4'd3, 10'd4);
    mem[20]      = 9'h023;
    taken_at[20] = 1'b1;
    run_program(10'd20, 0, -1, 4'd0, 10'd0);

    $display("[TB] backward branch with wrap, fall-through wrap");
    clear_program();
    write_lut(4'd1, 10'h3FD);
    mem[1]      = 9'h031;
    taken_at[1] = 1'b1;
    run_program(10'd1, 0, -1, 4'd0, 10'd0);
    clear_program();
    mem[10'h3FF] = 9'h010;
    run_program(10'h3FF, 0, -1, 4'd0, 10'd0);

    $display("[TB] halt at start address, then restart");
    clear_program();
    taken_at[50] = 1'b1;
    mem[51]      = 9'h0AA;
    run_program(10'd50, 0, -1, 4'd0, 10'd0);
    run_program(10'd51, 0, -1, 4'd0, 10'd0);

    $display("[TB] start pulse during run");
    clear_program();
    for (int i = 40; i < 50; i++) mem[i] = 9'($urandom_range(0, 255));
    run_program(10'd40, 1, 3, 4'd0, 10'd0);

    $display("[TB] same-cycle LUT write and branch");
    clear_program();
    write_lut(4'd5, 10'd2);
    mem[60]      = 9'h005;
    taken_at[60] = 1'b1;
    run_program(10'd60, 2, 0, 4'd5, 10'd7);

    $display("[TB] random programs");
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++) write_lut(4'(i), 10'($urandom));
      ok  = 1'b0;
      spc = 10'($urandom);
      for (int r = 0; r < 20 && !ok; r++) begin
        for (int i = 0; i < 1024; i++) begin
          mem[i]      = ($urandom_range(0, 7) == 0) ? HALT : 9'($urandom_range(0, 510));
          taken_at[i] = 1'($urandom_range(0, 1));
        end
        build_expected(spc, 1'b0, hp, n, ok);
      end
      if (!ok) mem[spc] = HALT;
      run_program(spc, 0, -1, 4'd0, 10'd0);
    end

    $display("[TB] reset during run");
    clear_program();
    for (int i = 5; i < 10; i++) mem[i] = 9'(9'h020 + i);
    build_expected(10'd5, 1'b1, hp, n, ok);
    apply_stimulus(10'd5);
    hit = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (pc == 10'd7) begin
        hit = 1'b1;
        break;
      end
    end
    check_output("reached_pc7", {31'd0, hit}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_output("abort_pc", {22'd0, pc}, 32'd0);
    check_output("abort_valid", {31'd0, bus.instr_valid}, 32'd0);
    check_output("abort_instr", {23'd0, bus.instr}, 32'd0);
    check_output("abort_count", {16'd0, instr_count}, 32'd0);
    check_output("abort_done", {31'd0, done}, 32'd0);
    sb.delete();
    for (int i = 0; i < 16; i++) lut_model[i] = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_output("post_abort_idle_valid", {31'd0, bus.instr_valid}, 32'd0);
    check_output("post_abort_idle_done", {31'd0, done}, 32'd0);
    check_output("post_abort_idle_pc", {22'd0, pc}, 32'd0);

    $display("[TB] count saturation with zero-offset loop");
    clear_program();
    mem[100]      = 9'h010;
    taken_at[100] = 1'b1;
    mon_en        = 1'b0;
    apply_stimulus(10'd100);
    repeat (1000) @(posedge clk);
    #1;
    check_output("count_1000", {16'd0, instr_count}, 32'd1000);
    repeat (69000) @(posedge clk);
    #1;
    check_output("count_saturated", {16'd0, instr_count}, 32'h0000_FFFF);
    check_output("loop_pc", {22'd0, pc}, 32'd100);
    check_output("loop_valid", {31'd0, bus.instr_valid}, 32'd1);
    check_output("loop_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #3;
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Producer end of the 9-bit instruction interface. Owns the program counter, drives instruction-memory addresses and presents one instruction per cycle to the decoder.
- Resolves taken branches (BNZ) through an internal 16-entry signed-offset jump LUT.
- Runs a start/done program handshake with the testbench or top level.

Parameters:
- PC_W, 10, width of program counter, instruction-memory address and jump offsets.
- HALT_INSTR, 9'h1FF, encoding that terminates the program; it is never issued to the decoder.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse; begins execution at start_pc
- start_pc  input  PC_W  first instruction address, sampled on start
- done  output  1  high while in HALTED
- imem_addr  output  PC_W  instruction memory address; equals pc
- imem_rdata  input  9  asynchronous-read instruction memory data for imem_addr
- instr  output  9  instruction to decoder; 9'd0 when instr_valid=0
- instr_valid  output  1  instr is a live instruction this cycle; decoder writes are gated by it
- branch_taken  input  1  ALU BNZ result for the current instr, same cycle
- lut_we  input  1  jump LUT write enable
- lut_idx  input  4  jump LUT write index
- lut_data  input  PC_W  signed two's-complement offset to write
- pc  output  PC_W  current program counter
- instr_count  output  16  instructions issued since last start, saturating

Behaviour:
- Reset (async, immediate): state=IDLE, pc=0, done=0, instr_valid=0, instr=0, instr_count=0, all 16 LUT entries=0.
- States: IDLE, RUN, HALTED.
- IDLE: start=1 -> pc<=start_pc, instr_count<=0, RUN next cycle. Otherwise hold.
- RUN, normal issue: imem_rdata != HALT_INSTR -> instr=imem_rdata, instr_valid=1 (combinational from pc, zero latency), instr_count increments (saturates at 16'hFFFF).
- RUN, next pc: pc<=pc+1, or pc<=pc+sext(LUT[imem_rdata[3:0]]) when branch_taken=1.
- RUN, halt: imem_rdata == HALT_INSTR -> instr_valid=0, instr=0, branch_taken ignored, pc holds, count unchanged, state<=HALTED.
- HALTED: done=1, pc holds at the halt address, instr_valid=0. start=1 -> same as IDLE start (done drops next cycle).
- start while in RUN is ignored.
- branch_taken is ignored whenever instr_valid=0.
- pc arithmetic is modulo 2^PC_W. Wrap past max address, and negative offsets below 0, wrap silently.
- Offset 0 with a taken branch re-issues the same address every cycle (legal infinite loop).
- LUT write is allowed in any state and takes effect next cycle. A same-cycle branch lookup on the same index uses the old value.
- Reset asserted mid-RUN aborts immediately to the reset values. LUT contents are lost.

Test Plan:
- Reset, LUT[2]=+5. Pulse start, start_pc=10; memory 10..12 = 9'h040, 9'h041, HALT. Required: instr sequence 040, 041 with instr_valid=1. Then done=1 with pc=12, instr_count=2.
- Branch forward: LUT[3]=+4; instr at 20 ends in 4'h3 with branch_taken=1. Required: next pc=24, count +1.
- Branch backward with wrap: LUT[1]=-3 (10'h3FD) at pc=1 taken. Required: next pc=10'h3FE. Separately, pc=10'h3FF not taken -> pc=0.
- Halt semantics: HALT at start_pc. Required: instr_valid never asserts, instr_count=0, done=1 on the 2nd cycle after start. A second start pulse then reruns from the new start_pc.
- Corner cases: reset asserted mid-RUN at pc=7 -> outputs 0 and IDLE asynchronously. start during RUN -> no pc change. A same-cycle LUT write and branch on idx 5 -> old offset used.
- Saturation: loop with offset 0 taken for 70000 cycles. Required: instr_count stays at 16'hFFFF.
